// File: rtl/cnn_mem_pkg.sv
// Shared constants for the dual-port SRAM: collision policies and FSM state encoding.
package cnn_mem_pkg;

    localparam int unsigned READ_OLD      = 0;
    localparam int unsigned WRITE_THROUGH = 1;

    typedef enum logic {
        StClear = 1'b0,
        StIdle  = 1'b1
    } sram_state_e;

endpackage

// File: rtl/sram_dp_if.sv
// Request/response bundle between a client and the dual-port SRAM.
interface sram_dp_if #(
    parameter int unsigned A = 7,
    parameter int unsigned W = 16
);
    logic         clear;
    logic         write;
    logic [A-1:0] writeAddress;
    logic [W-1:0] dataInput;
    logic         read;
    logic [A-1:0] readAddress;
    logic [W-1:0] dataOutput;
    logic         readValid;
    logic         busy;

    modport master (
        output clear, write, writeAddress, dataInput, read, readAddress,
        input  dataOutput, readValid, busy
    );

    modport slave (
        input  clear, write, writeAddress, dataInput, read, readAddress,
        output dataOutput, readValid, busy
    );
endinterface

// File: rtl/sram_array.sv
// Storage core: one synchronous write port, one asynchronous read port, no reset.
module sram_array #(
    parameter int unsigned A = 7,
    parameter int unsigned W = 16
) (
    input  logic         CLK,
    input  logic         we,
    input  logic [A-1:0] waddr,
    input  logic [W-1:0] wdata,
    input  logic [A-1:0] raddr,
    output logic [W-1:0] rdata
);
    localparam int unsigned Depth = 2 ** A;

    logic [W-1:0] mem [Depth];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sram_dp.sv
// Dual-port SRAM with a hardware clear sequence, registered read data and a
// selectable same-address collision policy.
module sram_dp
    import cnn_mem_pkg::*;
#(
    parameter int unsigned A         = 7,
    parameter int unsigned W         = 16,
    parameter int unsigned COLLISION = 0
) (
    input  logic       CLK,
    input  logic       RST,
    sram_dp_if.slave   bus
);
    sram_state_e  state;
    logic [A:0]   clearPtr;
    logic [A:0]   clearPtrNext;
    logic         idle;
    logic         writeAccept;
    logic         readAccept;
    logic         arrWe;
    logic [A-1:0] arrWaddr;
    logic [W-1:0] arrWdata;
    logic [W-1:0] arrRdata;
    logic [W-1:0] readWord;
    logic [W-1:0] dataOutputQ;
    logic         readValidQ;

    assign idle = (state == StIdle);

    always_comb begin
        writeAccept  = idle && bus.write && !bus.clear;
        readAccept   = idle && bus.read;
        clearPtrNext = clearPtr + {{A{1'b0}}, 1'b1};

        // Clear sequence owns the write port; no array writes while held in reset.
        if (!idle) begin
            arrWe    = !RST;
            arrWaddr = clearPtr[A-1:0];
            arrWdata = '0;
        end else begin
            arrWe    = writeAccept && !RST;
            arrWaddr = bus.writeAddress;
            arrWdata = bus.dataInput;
        end

        readWord = arrRdata;
        if (COLLISION == WRITE_THROUGH && writeAccept &&
            bus.writeAddress == bus.readAddress) begin
            readWord = bus.dataInput;
        end
    end

    sram_array #(
        .A(A),
        .W(W)
    ) u_array (
        .CLK  (CLK),
        .we   (arrWe),
        .waddr(arrWaddr),
        .wdata(arrWdata),
        .raddr(bus.readAddress),
        .rdata(arrRdata)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= StClear;
            clearPtr    <= '0;
            readValidQ  <= 1'b0;
            dataOutputQ <= '0;
        end else begin
            readValidQ <= readAccept;
            if (readAccept) begin
                dataOutputQ <= readWord;
            end
            case (state)
                StClear: begin
                    // Carry into bit A marks that the last address has just been written.
                    if (clearPtrNext[A]) begin
                        state    <= StIdle;
                        clearPtr <= '0;
                    end else begin
                        clearPtr <= clearPtrNext;
                    end
                end
                StIdle: begin
                    if (bus.clear) begin
                        state    <= StClear;
                        clearPtr <= '0;
                    end
                end
                default: begin
                    state    <= StClear;
                    clearPtr <= '0;
                end
            endcase
        end
    end

    assign bus.busy       = (state == StClear);
    assign bus.readValid  = readValidQ;
    assign bus.dataOutput = dataOutputQ;
endmodule

// File: tb/tb_sram_dp.sv
// Randomised self-checking bench: two instances (read-old and write-through) driven in lockstep.
module tb_sram_dp;
    import cnn_mem_pkg::*;

    localparam int unsigned A     = 4;
    localparam int unsigned W     = 16;
    localparam int unsigned DEPTH = 16;

    typedef logic [A-1:0] addr_t;
    typedef logic [W-1:0] word_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    sram_dp_if #(.A(A), .W(W)) bus0 ();
    sram_dp_if #(.A(A), .W(W)) bus1 ();

    sram_dp #(.A(A), .W(W), .COLLISION(READ_OLD)) dut0 (
        .CLK(CLK),
        .RST(RST),
        .bus(bus0)
    );

    sram_dp #(.A(A), .W(W), .COLLISION(WRITE_THROUGH)) dut1 (
        .CLK(CLK),
        .RST(RST),
        .bus(bus1)
    );

    int    errors = 0;
    int    checks = 0;
    word_t model [DEPTH];

    task automatic drive(input logic clr, input logic wr, input addr_t wa, input word_t wd,
                         input logic rd, input addr_t ra);
        bus0.clear = clr; bus0.write = wr; bus0.writeAddress = wa; bus0.dataInput = wd;
        bus0.read = rd; bus0.readAddress = ra;
        bus1.clear = clr; bus1.write = wr; bus1.writeAddress = wa; bus1.dataInput = wd;
        bus1.read = rd; bus1.readAddress = ra;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        int n;
        RST = 1'b1;
        drive(0, 0, '0, '0, 0, '0);
        repeat (3) step();
        checks++;
        if (bus0.busy !== 1'b1 || bus1.busy !== 1'b1)
            $display("FAIL reset_busy: got %b/%b want 1", bus0.busy, bus1.busy);
        if (bus0.busy !== 1'b1 || bus1.busy !== 1'b1) errors++;
        checks++;
        if (bus0.readValid !== 1'b0 || bus1.readValid !== 1'b0 ||
            bus0.dataOutput !== 16'h0 || bus1.dataOutput !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got valid %b/%b data %h/%h want 0", bus0.readValid,
                     bus1.readValid, bus0.dataOutput, bus1.dataOutput);
        end
        RST = 1'b0;
        n = 0;
        while ((bus0.busy || bus1.busy) && n < 40) begin
            n++;
            step();
        end
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL reset_clear_len: got %0d busy cycles want %0d", n, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, '0, '0, 1, addr_t'(i));
            step();
            checks++;
            if (bus0.readValid !== 1'b1 || bus1.readValid !== 1'b1 ||
                bus0.dataOutput !== model[i] || bus1.dataOutput !== model[i]) begin
                errors++;
                $display("FAIL reset_readback[%0d]: got %b/%b %h/%h want 1 %h", i,
                         bus0.readValid, bus1.readValid, bus0.dataOutput, bus1.dataOutput,
                         model[i]);
            end
        end
        drive(0, 0, '0, '0, 0, '0);
        step();
        checks++;
        if (bus0.readValid !== 1'b0 || bus1.readValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid_drop: got %b/%b want 0", bus0.readValid, bus1.readValid);
        end
    endtask

    task automatic test_write_read();
        drive(0, 1, addr_t'(5), 16'hBEEF, 0, '0);
        model[5] = 16'hBEEF;
        step();
        drive(0, 0, '0, '0, 1, addr_t'(5));
        step();
        checks++;
        if (bus0.readValid !== 1'b1 || bus0.dataOutput !== 16'hBEEF ||
            bus1.readValid !== 1'b1 || bus1.dataOutput !== 16'hBEEF) begin
            errors++;
            $display("FAIL write_read: got %b/%b %h/%h want 1 beef", bus0.readValid,
                     bus1.readValid, bus0.dataOutput, bus1.dataOutput);
        end
        drive(0, 0, '0, '0, 0, '0);
        step();
        checks++;
        if (bus0.readValid !== 1'b0 || bus0.dataOutput !== 16'hBEEF ||
            bus1.readValid !== 1'b0 || bus1.dataOutput !== 16'hBEEF) begin
            errors++;
            $display("FAIL write_read_hold: got %b/%b %h/%h want 0 beef", bus0.readValid,
                     bus1.readValid, bus0.dataOutput, bus1.dataOutput);
        end
    endtask

    task automatic test_collision();
        drive(0, 1, addr_t'(3), 16'h1111, 0, '0);
        step();
        drive(0, 1, addr_t'(3), 16'h2222, 1, addr_t'(3));
        step();
        model[3] = 16'h2222;
        checks++;
        if (bus0.dataOutput !== 16'h1111 || bus1.dataOutput !== 16'h2222 ||
            bus0.readValid !== 1'b1 || bus1.readValid !== 1'b1) begin
            errors++;
            $display("FAIL collision: got %h/%h want 1111/2222", bus0.dataOutput,
                     bus1.dataOutput);
        end
        drive(0, 0, '0, '0, 1, addr_t'(3));
        step();
        checks++;
        if (bus0.dataOutput !== 16'h2222 || bus1.dataOutput !== 16'h2222) begin
            errors++;
            $display("FAIL collision_after: got %h/%h want 2222", bus0.dataOutput,
                     bus1.dataOutput);
        end
    endtask

    task automatic test_random();
        logic  wr, rd, seen;
        addr_t wa, ra;
        word_t wd, exp0, exp1;
        seen = 1'b0;
        exp0 = '0;
        exp1 = '0;
        for (int k = 0; k < 300; k++) begin
            wr = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            wa = addr_t'($urandom_range(0, DEPTH - 1));
            ra = addr_t'($urandom_range(0, DEPTH - 1));
            wd = word_t'($urandom);
            if ($urandom_range(0, 3) == 0) ra = wa;
            if (rd) begin
                exp0 = model[ra];
                exp1 = (wr && wa == ra) ? wd : model[ra];
                seen = 1'b1;
            end
            if (wr) model[wa] = wd;
            drive(0, wr, wa, wd, rd, ra);
            step();
            checks++;
            if (bus0.readValid !== rd || bus1.readValid !== rd) begin
                errors++;
                $display("FAIL random_valid[%0d]: got %b/%b want %b", k, bus0.readValid,
                         bus1.readValid, rd);
            end
            if (seen) begin
                checks++;
                if (bus0.dataOutput !== exp0 || bus1.dataOutput !== exp1) begin
                    errors++;
                    $display("FAIL random_data[%0d]: got %h/%h want %h/%h", k,
                             bus0.dataOutput, bus1.dataOutput, exp0, exp1);
                end
            end
        end
        drive(0, 0, '0, '0, 0, '0);
        step();
    endtask

    task automatic test_clear();
        int n;
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, addr_t'(i), word_t'(i), 0, '0);
            model[i] = word_t'(i);
            step();
        end
        drive(1, 1, addr_t'(7), 16'hFFFF, 0, '0);
        step();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        n = 0;
        while ((bus0.busy || bus1.busy) && n < 40) begin
            checks++;
            if (bus0.readValid !== 1'b0 || bus1.readValid !== 1'b0) begin
                errors++;
                $display("FAIL clear_busy_read[%0d]: got %b/%b want 0", n, bus0.readValid,
                         bus1.readValid);
            end
            n++;
            drive(0, 1, addr_t'($urandom_range(0, DEPTH - 1)), word_t'($urandom), 1,
                  addr_t'($urandom_range(0, DEPTH - 1)));
            step();
        end
        checks++;
        if (n != DEPTH || bus0.readValid !== 1'b0 || bus1.readValid !== 1'b0) begin
            errors++;
            $display("FAIL clear_len: got %0d cycles valid %b/%b want %0d 0", n,
                     bus0.readValid, bus1.readValid, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, '0, '0, 1, addr_t'(i));
            step();
            checks++;
            if (bus0.readValid !== 1'b1 || bus0.dataOutput !== model[i] ||
                bus1.readValid !== 1'b1 || bus1.dataOutput !== model[i]) begin
                errors++;
                $display("FAIL clear_readback[%0d]: got %h/%h want %h", i, bus0.dataOutput,
                         bus1.dataOutput, model[i]);
            end
        end
        drive(0, 0, '0, '0, 0, '0);
        step();
    endtask

    task automatic test_reset_mid_clear();
        int n;
        drive(0, 0, '0, '0, 1, addr_t'(2));
        RST = 1'b1;
        step();
        checks++;
        if (bus0.readValid !== 1'b0 || bus0.busy !== 1'b1 || bus0.dataOutput !== 16'h0 ||
            bus1.readValid !== 1'b0 || bus1.busy !== 1'b1 || bus1.dataOutput !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_read: got valid %b busy %b data %h want 0 1 0",
                     bus0.readValid, bus0.busy, bus0.dataOutput);
        end
        RST = 1'b0;
        drive(0, 0, '0, '0, 0, '0);
        n = 0;
        while ((bus0.busy || bus1.busy) && n < 40) begin
            n++;
            step();
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, addr_t'(i), word_t'(16'h0100 + i), 0, '0);
            step();
        end
        drive(1, 0, '0, '0, 0, '0);
        step();
        drive(0, 0, '0, '0, 0, '0);
        repeat (9) step();
        RST = 1'b1;
        step();
        checks++;
        if (bus0.busy !== 1'b1 || bus1.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_busy: got %b/%b want 1", bus0.busy, bus1.busy);
        end
        RST = 1'b0;
        // A clear request during the sequence must not restart it.
        drive(1, 0, '0, '0, 0, '0);
        n = 0;
        while ((bus0.busy || bus1.busy) && n < 40) begin
            n++;
            step();
            if (n == 20) drive(0, 0, '0, '0, 0, '0);
        end
        drive(0, 0, '0, '0, 0, '0);
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL reset_mid_len: got %0d busy cycles want %0d", n, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, '0, '0, 1, addr_t'(i));
            step();
            checks++;
            if (bus0.dataOutput !== model[i] || bus1.dataOutput !== model[i] ||
                bus0.readValid !== 1'b1 || bus1.readValid !== 1'b1) begin
                errors++;
                $display("FAIL reset_mid_readback[%0d]: got %h/%h want %h", i,
                         bus0.dataOutput, bus1.dataOutput, model[i]);
            end
        end
        drive(0, 0, '0, '0, 0, '0);
        step();
    endtask

    initial begin
        drive(0, 0, '0, '0, 0, '0);
        test_reset();
        test_write_read();
        test_collision();
        test_random();
        test_clear();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_dp.md
SRAM_DP -- requirements
Module: sram_dp

Interface
REQ-001 The block SHALL have parameter A, default 7, meaning address width; depth is 2^A words.
REQ-002 The block SHALL have parameter W, default 16, meaning word width in bits.
REQ-003 The block SHALL have parameter COLLISION, default 0, meaning same-address read/write policy: 0 = read-old, 1 = write-through.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RST  input  1  reset; synchronous, active-high.
REQ-006 clear  input  1  single-cycle request to re-zero the whole array.
REQ-007 write  input  1  write enable.
REQ-008 writeAddress  input  A  write address.
REQ-009 dataInput  input  W  write data.
REQ-010 read  input  1  read request.
REQ-011 readAddress  input  A  read address.
REQ-012 dataOutput  output  W  registered read data.
REQ-013 readValid  output  1  dataOutput updated this cycle, one-cycle pulse per accepted read.
REQ-014 busy  output  1  clear sequence in progress; write/read ignored while high.

Function
REQ-015 The block SHALL implement a two-state FSM: CLEAR and IDLE.
REQ-016 In CLEAR, the block SHALL write zero to address clearPtr each cycle, clearPtr counting 0 to 2^A-1, then enter IDLE on the cycle after address 2^A-1 is written.
REQ-017 busy SHALL be 1 exactly while the FSM is in CLEAR; a full clear therefore lasts 2^A cycles.
REQ-018 clear asserted in IDLE SHALL move the FSM to CLEAR with clearPtr=0 on the next edge; clear asserted in CLEAR SHALL be ignored (no restart).
REQ-019 In IDLE, write=1 SHALL store dataInput at writeAddress on that edge.
REQ-020 In IDLE, read=1 in cycle t SHALL present mem[readAddress] on dataOutput with readValid=1 in cycle t+1 (latency 1).
REQ-021 readValid SHALL be 0 in any cycle not following an accepted read; dataOutput SHALL hold its last value when readValid=0.
REQ-022 Read and write to different addresses in the same cycle SHALL both complete independently.
REQ-023 Same-address read and write in one cycle SHALL return the pre-write word if COLLISION=0, or dataInput if COLLISION=1.
REQ-024 read or write asserted while busy=1 SHALL be dropped: no array change, no readValid.
REQ-025 clear and write in the same IDLE cycle: clear SHALL win; the write is dropped.
REQ-026 Address arithmetic SHALL be modulo 2^A; clearPtr SHALL be A+1 bits wide to detect the terminal count without wrap ambiguity.

Reset
REQ-027 While RST=1: FSM in CLEAR, clearPtr=0, busy=1, readValid=0, dataOutput=0; no array writes.
REQ-028 After RST falls, the clear sequence of REQ-016 SHALL run from address 0; RST asserted mid-clear or mid-read SHALL restart this from scratch, discarding any pending readValid.
REQ-029 The array SHALL NOT depend on simulation-only initial contents; the clear sequence is the only initialisation.

Structure
REQ-030 Collision-mode constants (READ_OLD=0, WRITE_THROUGH=1) and FSM state encodings SHALL live in shared package cnn_mem_pkg.
REQ-031 Storage SHALL be a sub-module sram_array (one write port, one asynchronous read port, parameters A, W); the FSM, clear counter, collision mux and output register live in sram_dp.

Verification (A=4, W=16)
REQ-032 RST high 3 cycles then low -> busy=1 for exactly 16 cycles after release, then 0; subsequent reads of all 16 addresses return 0x0000 with readValid one cycle after each read.
REQ-033 Write 0xBEEF to address 5, next cycle read 5 -> dataOutput=0xBEEF, readValid=1 one cycle later, readValid=0 the cycle after.
REQ-034 Address 3 holds 0x1111; same cycle write 0x2222 and read address 3 -> dataOutput=0x1111 with COLLISION=0, 0x2222 with COLLISION=1; following read returns 0x2222 in both.
REQ-035 Fill addresses 0-15 with their index, pulse clear together with a write of 0xFFFF to 7 -> write dropped, busy=1 for 16 cycles, reads during busy produce no readValid, all words read 0 afterward.
REQ-036 Assert RST for 1 cycle at clearPtr=9 -> busy stays 1, clear restarts at 0, busy falls exactly 16 cycles after RST release.
